// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing arbiter.
package mult_share_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_ACK  = 3'd2,
      WAIT_DONE = 3'd3,
      RESPOND   = 3'd4
   } state_t;

   localparam int BIT_DEFAULT     = 5;
   localparam int NREQ_DEFAULT    = 4;
   localparam int TIMEOUT_DEFAULT = 64;

   // Round-robin pointer width; a single requester still needs one bit.
   function automatic int ptr_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   function automatic int wd_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest
// set bit, rotate the winning position back into client numbering.
module mult_share_arbiter_rr_picker
   import mult_share_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEFAULT,
   parameter int PTR_W = ptr_width(NREQ_DEFAULT)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   logic [2*NREQ-1:0] req_shifted;
   logic [NREQ-1:0]   req_rot;
   logic [PTR_W-1:0]  rot_pos;
   logic [PTR_W:0]    idx_sum;

   assign req_shifted = {req, req} >> ptr;
   assign req_rot     = req_shifted[NREQ-1:0];
   assign any         = |req;

   always_comb begin
      rot_pos = '0;
      // Scan downward so the lowest set bit (highest priority) wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rot_pos = PTR_W'(i);
         end
      end
   end

   always_comb begin
      idx_sum = {1'b0, rot_pos} + {1'b0, ptr};
      if (idx_sum >= (PTR_W + 1)'(NREQ)) begin
         idx_sum = idx_sum - (PTR_W + 1)'(NREQ);
      end
   end

   assign idx = idx_sum[PTR_W-1:0];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
         assign grant[gi] = any && (idx == PTR_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one start/ready sequential multiplier among NREQ clients with
// round-robin arbitration, operand latching and a hung-multiplier watchdog.
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int BIT     = BIT_DEFAULT,
   parameter int NREQ    = NREQ_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*BIT-1:0] op_b,
   input  logic [NREQ*BIT-1:0] op_q,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [2*BIT-1:0]    rsp_product,
   output logic                busy,
   output logic                err,
   output logic                mul_start,
   output logic [BIT-1:0]      mul_b,
   output logic [BIT-1:0]      mul_q,
   input  logic                mul_ready,
   input  logic [2*BIT-1:0]    mul_product
);

   localparam int PTR_W = ptr_width(NREQ);
   localparam int WD_W  = wd_width(TIMEOUT);

   state_t            state_reg;
   logic [PTR_W-1:0]  ptr_reg;
   logic [PTR_W-1:0]  idx_reg;
   logic [NREQ-1:0]   gnt_reg;
   logic [NREQ-1:0]   rsp_valid_reg;
   logic [2*BIT-1:0]  rsp_product_reg;
   logic              err_reg;
   logic              mul_start_reg;
   logic [BIT-1:0]    mul_b_reg;
   logic [BIT-1:0]    mul_q_reg;
   logic [WD_W-1:0]   wd_reg;

   logic [NREQ-1:0]   pick_grant;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_any;
   logic [BIT-1:0]    op_b_arr [NREQ];
   logic [BIT-1:0]    op_q_arr [NREQ];
   logic              wd_expired;
   logic [PTR_W-1:0]  next_ptr;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign op_b_arr[gi] = op_b[gi*BIT +: BIT];
         assign op_q_arr[gi] = op_q[gi*BIT +: BIT];
      end
   endgenerate

   mult_share_arbiter_rr_picker #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign wd_expired = (wd_reg == WD_W'(TIMEOUT - 1));
   assign next_ptr   = (idx_reg == PTR_W'(NREQ - 1)) ? '0 : idx_reg + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         ptr_reg         <= '0;
         idx_reg         <= '0;
         gnt_reg         <= '0;
         rsp_valid_reg   <= '0;
         rsp_product_reg <= '0;
         err_reg         <= 1'b0;
         mul_start_reg   <= 1'b0;
         mul_b_reg       <= '0;
         mul_q_reg       <= '0;
         wd_reg          <= '0;
      end else begin
         // Pulses and the watchdog clear unless a state explicitly holds them.
         mul_start_reg <= 1'b0;
         rsp_valid_reg <= '0;
         wd_reg        <= '0;
         case (state_reg)
            IDLE: begin
               if (pick_any && mul_ready) begin
                  gnt_reg   <= pick_grant;
                  idx_reg   <= pick_idx;
                  mul_b_reg <= op_b_arr[pick_idx];
                  mul_q_reg <= op_q_arr[pick_idx];
                  state_reg <= LAUNCH;
               end
            end
            LAUNCH: begin
               mul_start_reg <= 1'b1;
               state_reg     <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (!mul_ready) begin
                  state_reg <= WAIT_DONE;
               end else if (wd_expired) begin
                  err_reg         <= 1'b1;
                  rsp_product_reg <= '0;
                  rsp_valid_reg   <= gnt_reg;
                  state_reg       <= RESPOND;
               end else begin
                  wd_reg <= wd_reg + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (mul_ready) begin
                  rsp_product_reg <= mul_product;
                  rsp_valid_reg   <= gnt_reg;
                  state_reg       <= RESPOND;
               end else if (wd_expired) begin
                  err_reg         <= 1'b1;
                  rsp_product_reg <= '0;
                  rsp_valid_reg   <= gnt_reg;
                  state_reg       <= RESPOND;
               end else begin
                  wd_reg <= wd_reg + 1'b1;
               end
            end
            RESPOND: begin
               gnt_reg   <= '0;
               ptr_reg   <= next_ptr;
               state_reg <= IDLE;
            end
            default: begin
               gnt_reg   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign gnt         = gnt_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_product = rsp_product_reg;
   assign busy        = (state_reg != IDLE);
   assign err         = err_reg;
   assign mul_start   = mul_start_reg;
   assign mul_b       = mul_b_reg;
   assign mul_q       = mul_q_reg;

endmodule
